bc_round_ctrl: RTL and testbench



---
 rtl/bc_pkg.sv | 35 +++
 rtl/bc_dup_check.sv | 20 ++
 rtl/bc_round_ctrl.sv | 134 +++++++++++++
 tb/tb_bc_round_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_SCORE,
        ST_RESULT,
        ST_WIN,
        ST_LOSE
    } bc_state_t;

    localparam int          NUM_DIGITS  = 4;
    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [3:0]  KEY_BS      = 4'hB;
    localparam logic [3:0]  MAX_DIGIT   = 4'd9;
    localparam logic [2:0]  WIN_STRIKES = 3'd4;
    localparam logic [15:0] GUESS_BLANK = {NUM_DIGITS{DIGIT_BLANK}};

    // Slot 0 lives in the top nibble, slot 3 in the bottom nibble.
    function automatic logic [15:0] set_slot(input logic [15:0] g,
                                             input logic [1:0]  idx,
                                             input logic [3:0]  d);
        logic [15:0] r;
        r = g;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 2'(i)) r[(NUM_DIGITS-1-i)*4 +: 4] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bc_dup_check.sv
// Flags a 4-digit guess that contains any repeated digit (6 pairwise compares).
// Latency: combinational.
// Backpressure: none.
module bc_dup_check
    import bc_pkg::*;
(
    input  logic [15:0] guess,
    output logic        dup
);

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (guess[i*4 +: 4] == guess[j*4 +: 4]) dup = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bc_round_ctrl.sv
// Round controller: keypad digit entry, guess validation, scorer handshake, win/lose. Macro BC_BACKSPACE_EN enables key 4'hB as backspace.
// Latency: 4th digit to score_req 2 cycles; score_ack to win/lose 2 cycles.
// Backpressure: score_req held until score_ack; keys outside entry are dropped.
module bc_round_ctrl
    import bc_pkg::*;
#(
    parameter int MAX_TRIES = 10,
    parameter int TRY_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             score_ack,
    input  logic [2:0]       strikes,
    input  logic [2:0]       balls,
    output logic [15:0]      guess,
    output logic             score_req,
    output logic [TRY_W-1:0] try_cnt,
    output logic [2:0]       last_strikes,
    output logic [2:0]       last_balls,
    output logic             err_range,
    output logic             err_dup,
    output logic             win,
    output logic             lose,
    output logic             busy
);

    localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

    bc_state_t  state;
    logic [1:0] idx;
    logic       dup;

    bc_dup_check u_dup_check (
        .guess (guess),
        .dup   (dup)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            guess        <= GUESS_BLANK;
            idx          <= 2'd0;
            try_cnt      <= '0;
            last_strikes <= 3'd0;
            last_balls   <= 3'd0;
            score_req    <= 1'b0;
            err_range    <= 1'b0;
            err_dup      <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            err_range <= 1'b0;
            err_dup   <= 1'b0;
            case (state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state        <= ST_ENTRY;
                        guess        <= GUESS_BLANK;
                        idx          <= 2'd0;
                        try_cnt      <= '0;
                        last_strikes <= 3'd0;
                        last_balls   <= 3'd0;
                        win          <= 1'b0;
                        lose         <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (key_digit <= MAX_DIGIT) begin
                            guess <= set_slot(guess, idx, key_digit);
                            idx   <= idx + 2'd1;
                            if (idx == IDX_LAST) state <= ST_CHECK;
                        end
`ifdef BC_BACKSPACE_EN
                        else if (key_digit == KEY_BS) begin
                            // Backspace on an empty guess is silently dropped.
                            if (idx != 2'd0) begin
                                guess <= set_slot(guess, idx - 2'd1, DIGIT_BLANK);
                                idx   <= idx - 2'd1;
                            end
                        end
`endif
                        else begin
                            err_range <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (dup) begin
                        err_dup <= 1'b1;
                        guess   <= GUESS_BLANK;
                        idx     <= 2'd0;
                        state   <= ST_ENTRY;
                    end else begin
                        score_req <= 1'b1;
                        state     <= ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    if (score_ack) begin
                        last_strikes <= strikes;
                        last_balls   <= balls;
                        try_cnt      <= try_cnt + TRY_W'(1);
                        score_req    <= 1'b0;
                        state        <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    // A winning final attempt takes precedence over running out of tries.
                    if (last_strikes == WIN_STRIKES) begin
                        win   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_WIN;
                    end else if (try_cnt == TRY_W'(MAX_TRIES)) begin
                        lose  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_LOSE;
                    end else begin
                        guess <= GUESS_BLANK;
                        idx   <= 2'd0;
                        state <= ST_ENTRY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Randomized bench for bc_round_ctrl: a game-level model predicts output events into a queue,
// and an independent monitor pops and compares each event the DUT presents.
module tb_bc_round_ctrl;

    localparam int MT = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          key_valid;
    logic [3:0]    key_digit;
    logic          score_ack;
    logic [2:0]    strikes;
    logic [2:0]    balls;
    logic [15:0]   guess;
    logic          score_req;
    logic [TW-1:0] try_cnt;
    logic [2:0]    last_strikes;
    logic [2:0]    last_balls;
    logic          err_range;
    logic          err_dup;
    logic          win;
    logic          lose;
    logic          busy;

    bc_round_ctrl #(.MAX_TRIES(MT), .TRY_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .score_ack    (score_ack),
        .strikes      (strikes),
        .balls        (balls),
        .guess        (guess),
        .score_req    (score_req),
        .try_cnt      (try_cnt),
        .last_strikes (last_strikes),
        .last_balls   (last_balls),
        .err_range    (err_range),
        .err_dup      (err_dup),
        .win          (win),
        .lose         (lose),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef enum int {E_IDLE, E_BUSY, E_RANGE, E_DUP, E_REQ, E_WIN, E_LOSE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [15:0] guess;
        int          tries;
        int          ls;
        int          lb;
        bit          req;
        bit          busy;
    } ev_t;

    ev_t expq[$];

    // ---------------- game-level reference model ----------------
    bit          m_game  = 0;
    bit          m_entry = 0;
    bit          m_score = 0;
    bit          m_done  = 0;
    int          m_dig[4];
    int          m_n     = 0;
    int          m_tries = 0;
    int          m_ls    = 0;
    int          m_lb    = 0;
    logic [15:0] m_full  = 16'hFFFF;

    function automatic logic [15:0] m_guess();
        logic [15:0] g;
        g = 16'hFFFF;
        for (int i = 0; i < m_n; i++) g[15-4*i -: 4] = 4'(m_dig[i]);
        return g;
    endfunction

    function automatic void push(ev_kind_t k, int c, logic [15:0] g, bit req, bit bsy);
        ev_t e;
        e.kind = k; e.cyc = c; e.guess = g; e.tries = m_tries;
        e.ls = m_ls; e.lb = m_lb; e.req = req; e.busy = bsy;
        expq.push_back(e);
    endfunction

    function automatic void model_key(int k, int n);
        bit [9:0] seen;
        bit       rep;
        if (!m_entry) return;
        if (k <= 9) begin
            m_dig[m_n] = k;
            m_n++;
            if (m_n == 4) begin
                m_done = 1;
                seen = '0;
                rep = 0;
                for (int i = 0; i < 4; i++) begin
                    if (seen[m_dig[i]]) rep = 1;
                    seen[m_dig[i]] = 1'b1;
                end
                if (rep) begin
                    m_n = 0;
                    push(E_DUP, n + 1, 16'hFFFF, 0, 1);
                end else begin
                    m_full  = m_guess();
                    m_entry = 0;
                    m_score = 1;
                    push(E_REQ, n + 1, m_full, 1, 1);
                end
            end
        end
`ifdef BC_BACKSPACE_EN
        else if (k == 11) begin
            if (m_n > 0) m_n--;
        end
`endif
        else begin
            push(E_RANGE, n, m_guess(), 0, 1);
        end
    endfunction

    function automatic void model_ack(int s, int b, int n);
        if (!m_score) return;
        m_score = 0;
        m_tries++;
        m_ls = s;
        m_lb = b;
        if (s == 4) begin
            m_game = 0;
            push(E_WIN, n + 1, m_full, 0, 0);
        end else if (m_tries == MT) begin
            m_game = 0;
            push(E_LOSE, n + 1, m_full, 0, 0);
        end else begin
            m_entry = 1;
            m_n = 0;
        end
    endfunction

    function automatic void model_start(int n);
        if (m_game) return;
        m_game = 1; m_entry = 1; m_score = 0; m_n = 0;
        m_tries = 0; m_ls = 0; m_lb = 0;
        push(E_BUSY, n, 16'hFFFF, 0, 1);
    endfunction

    function automatic void model_reset(int n);
        m_tries = 0; m_ls = 0; m_lb = 0; m_n = 0;
        m_entry = 0; m_score = 0;
        if (m_game) push(E_IDLE, n, 16'hFFFF, 0, 0);
        m_game = 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit   mon_en = 0;
    logic p_busy = 1'b0, p_req = 1'b0, p_win = 1'b0, p_lose = 1'b0;

    task automatic observe(input ev_kind_t k);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, expected no event", k.name(), cyc);
            return;
        end
        e = expq.pop_front();
        if (k != e.kind || cyc != e.cyc || guess !== e.guess || try_cnt !== TW'(e.tries) ||
            last_strikes !== 3'(e.ls) || last_balls !== 3'(e.lb) ||
            score_req !== e.req || busy !== e.busy) begin
            errors++;
            $display("FAIL event_%s: got kind=%s cyc=%0d guess=%h try=%0d last=%0d/%0d req=%b busy=%b; expected kind=%s cyc=%0d guess=%h try=%0d last=%0d/%0d req=%b busy=%b",
                     e.kind.name(), k.name(), cyc, guess, try_cnt, last_strikes, last_balls, score_req, busy,
                     e.kind.name(), e.cyc, e.guess, e.tries, e.ls, e.lb, e.req, e.busy);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (p_busy && !busy && !win && !lose) observe(E_IDLE);
            if (!p_busy && busy)                  observe(E_BUSY);
            if (err_range)                        observe(E_RANGE);
            if (err_dup)                          observe(E_DUP);
            if (!p_req && score_req)              observe(E_REQ);
            if (!p_win && win)                    observe(E_WIN);
            if (!p_lose && lose)                  observe(E_LOSE);
            p_busy = busy;
            p_req  = score_req;
            p_win  = win;
            p_lose = lose;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        start     = 1'b0;
        score_ack = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_digit = k;
        model_key(int'(k), cyc + 1);
        tick();
    endtask

    // Traffic the DUT must ignore in its current state.
    task automatic junk(input bit allow_ack, input bit allow_start);
        key_valid = 1'($urandom_range(0, 1));
        key_digit = 4'($urandom_range(0, 15));
        score_ack = allow_ack ? 1'($urandom_range(0, 1)) : 1'b0;
        start     = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
        strikes   = 3'($urandom_range(0, 7));
        balls     = 3'($urandom_range(0, 7));
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start(cyc + 1);
        tick();
    endtask

    task automatic play(input logic [15:0] g, input int s, input int b, input bit noisy);
        int guard;
        guard  = 0;
        m_done = 0;
        while (!m_done && guard < 64) begin
            guard++;
            if (noisy && $urandom_range(0, 5) == 0) begin
                key(4'($urandom_range(10, 15)));
            end else if (noisy && $urandom_range(0, 7) == 0) begin
                tick();
            end else begin
                if (noisy && $urandom_range(0, 7) == 0) start = 1'b1;
                key(g[15-4*m_n -: 4]);
            end
        end
        if (!m_done) begin
            checks++;
            errors++;
            $display("FAIL play_guard: got %0d digits entered, expected 4", m_n);
            return;
        end
        junk(1, 1);
        if (m_score) begin
            repeat ($urandom_range(0, 3)) junk(0, 1);
            score_ack = 1'b1;
            strikes   = 3'(s);
            balls     = 3'(b);
            model_ack(s, b, cyc + 1);
            tick();
            junk(1, 1);
        end
    endtask

    function automatic logic [15:0] rand_guess();
        logic [15:0] g;
        bit [9:0]    used;
        bit          uniq;
        int          d;
        used = '0;
        uniq = ($urandom_range(0, 2) != 0);
        g = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 9);
            if (uniq) while (used[d]) d = $urandom_range(0, 9);
            used[d] = 1'b1;
            g[15-4*i -: 4] = 4'(d);
        end
        return g;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        score_ack = 1'b0; strikes = 3'd0; balls = 3'd0;
        repeat (2) tick();
        chk("rst_guess",     guess, 32'hFFFF);
        chk("rst_score_req", score_req, 0);
        chk("rst_try_cnt",   try_cnt, 0);
        chk("rst_last",      {last_strikes, last_balls}, 0);
        chk("rst_errs",      {err_range, err_dup}, 0);
        chk("rst_win_lose",  {win, lose}, 0);
        chk("rst_busy",      busy, 0);
        rst_n = 1'b1;
        mon_en = 1;
        score_ack = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
        tick();

        // Directed game: scored guess, duplicate, range errors, win on the last try.
        do_start();
        play(16'h1234, 1, 2, 0);
        play(16'h5567, 0, 0, 0);
        key(4'h1);
        key(4'hC);
        key(4'hB);
        key(4'hC);
        play(16'h9876, 4, 3, 0);
        repeat (3) junk(1, 0);
        chk("win_level", win, 1);

        // Directed game: lose after MT non-winning tries, oversize scorer result.
        do_start();
        play(16'h1357, 1, 1, 0);
        play(16'h2468, 0, 7, 0);
        repeat (2) junk(1, 0);
        chk("lose_level", lose, 1);
        chk("lose_try_cnt", try_cnt, MT);

        // Random games.
        for (int gm = 0; gm < 30; gm++) begin
            do_start();
            while (m_game) begin
                s = ($urandom_range(0, 4) == 0) ? 4 : $urandom_range(0, 3);
                play(rand_guess(), s, $urandom_range(0, 7), 1);
            end
            repeat ($urandom_range(1, 3)) junk(1, 0);
        end

        // Reset while score_req is outstanding, then a late ack in IDLE.
        do_start();
        key(4'h4); key(4'h0); key(4'h2); key(4'h7);
        junk(1, 1);
        repeat (2) junk(0, 1);
        rst_n = 1'b0;
        model_reset(cyc + 1);
        tick();
        rst_n = 1'b1;
        score_ack = 1'b1; strikes = 3'd4; balls = 3'd0;
        tick();
        repeat (2) junk(1, 0);
        chk("post_rst_req", score_req, 0);
        chk("post_rst_win", win, 0);

        do_start();
        play(16'h0123, 4, 0, 1);
        repeat (4) tick();
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
